// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Define IFU_STALL_CNT_EN to add the stall/squash counter outputs to instr_fetch_unit.
package instr_fetch_unit_pkg;

    localparam int              WORD_W        = 32;
    localparam logic [WORD_W-1:0] PC_INC_DEF    = 32'd4;
    localparam logic [WORD_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } ifu_state_t;

    function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch PC register: word-aligned redirect load or sequential increment.
// A load always wins over an increment.
module ifu_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] PC_INC   = PC_INC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_load_pc,
    input  logic              i_inc,
    output logic [WORD_W-1:0] o_pc
);

    logic [WORD_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= align_pc(i_load_pc);
        end else if (i_inc) begin
            r_pc <= r_pc + PC_INC;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads at the PC and hands fetched words to decode.
// Define IFU_STALL_CNT_EN to add stall_cnt / squash_cnt saturating counters.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [WORD_W-1:0] PC_INC   = PC_INC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              halt,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] npc_out,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [WORD_W-1:0] stall_cnt,
    output logic [WORD_W-1:0] squash_cnt
`endif
);

    ifu_state_t        r_state;
    logic              r_imem_req;
    logic              r_instr_valid;
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pc_out;
    logic [WORD_W-1:0] r_npc_out;
    logic [WORD_W-1:0] r_pend_pc;

    logic              w_load;
    logic              w_inc;
    logic [WORD_W-1:0] w_load_pc;
    logic [WORD_W-1:0] w_pc;

    // The PC only moves when no request is outstanding at the old address.
    always_comb begin
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_load_pc = redirect_pc;
        case (r_state)
            IDLE:  w_load = redirect_valid;
            REQ:   w_load = redirect_valid && imem_ready;
            DRAIN: begin
                w_load = imem_ready;
                if (!redirect_valid) w_load_pc = r_pend_pc;
            end
            HOLD: begin
                w_load = redirect_valid;
                w_inc  = !redirect_valid && instr_ready;
            end
            default: ;
        endcase
    end

    ifu_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_load_pc (w_load_pc),
        .i_inc     (w_inc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_pc_out      <= '0;
            r_npc_out     <= '0;
            r_pend_pc     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!redirect_valid && en && !halt) begin
                        r_state    <= REQ;
                        r_imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        if (!redirect_valid) begin
                            r_instr       <= imem_rdata;
                            r_pc_out      <= w_pc;
                            r_npc_out     <= w_pc + PC_INC;
                            r_state       <= HOLD;
                            r_imem_req    <= 1'b0;
                            r_instr_valid <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        // Memory still owes us a word at the old address; wait it out.
                        r_pend_pc <= align_pc(redirect_pc);
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (redirect_valid) r_pend_pc <= align_pc(redirect_pc);
                    if (imem_ready)     r_state   <= REQ;
                end
                HOLD: begin
                    if (redirect_valid) begin
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= REQ;
                    end else if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_state <= IDLE;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= REQ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = w_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign npc_out     = r_npc_out;

`ifdef IFU_STALL_CNT_EN
    logic [WORD_W-1:0] r_stall_cnt;
    logic [WORD_W-1:0] r_squash_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_squash_cnt <= '0;
        end else begin
            if ((r_state == REQ || r_state == DRAIN) && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (redirect_valid && r_state != IDLE && r_squash_cnt != '1)
                r_squash_cnt <= r_squash_cnt + 1'b1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign squash_cnt = r_squash_cnt;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Producer side of the instruction word consumed by the control decoder. Holds the PC and issues word reads to instruction memory over a req/ready handshake. Presents each fetched 32-bit instruction with valid/ready to the decode stage of the multi-cycle core. Accepts redirects (branch/jump/JR/JALR targets) computed downstream from the decoder's BRANCH/JUMP/JUMP_USE_REG outcome.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, sequential PC increment in bytes

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
en  in  1  start fetching from IDLE
halt  in  1  stop after the current instruction is consumed
imem_req  out  1  read request to instruction memory
imem_addr  out  32  word address of request, = pc
imem_ready  in  1  read complete this cycle; imem_rdata valid
imem_rdata  in  32  returned instruction word
instr_valid  out  1  instr/pc_out/npc_out valid for decode
instr  out  32  instruction word to decoder
pc_out  out  32  PC of instr
npc_out  out  32  pc_out + PC_INC (JAL/JALR link value)
instr_ready  in  1  decode consumes instr this cycle
redirect_valid  in  1  load new PC, squash in-flight work
redirect_pc  in  32  redirect target

Behaviour:
- Clock/reset: one clock; reset is asynchronous, active-low (rst_n). On reset: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, pc_out=0, npc_out=0.
- imem_addr = pc at all times; imem_addr stable while imem_req=1.
- redirect_pc[1:0] forced to 2'b00 on load. PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 = 0.
- States: IDLE, REQ, DRAIN, HOLD.
- IDLE: imem_req=0, instr_valid=0. redirect_valid loads pc, stay IDLE. en=1 and halt=0 -> REQ next cycle.
- REQ: imem_req=1.
  - imem_ready=1, redirect_valid=0: capture instr=imem_rdata, pc_out=pc, npc_out=pc+PC_INC -> HOLD.
  - imem_ready=1, redirect_valid=1: discard rdata, pc=redirect_pc, stay REQ.
  - imem_ready=0, redirect_valid=1: latch target into pend_pc -> DRAIN. The request is never withdrawn.
  - Neither asserted: stay REQ.
- DRAIN: imem_req=1 at old address; a newer redirect_valid overwrites pend_pc. On imem_ready: discard rdata, pc=pend_pc (or redirect_pc if asserted that cycle) -> REQ.
- HOLD: instr_valid=1; outputs stable until consumed.
  - redirect_valid=1 (wins over instr_ready): instr_valid drops next cycle, pc=redirect_pc -> REQ.
  - Otherwise instr_ready=1: pc=pc+PC_INC -> IDLE if halt=1, else REQ.
- Latency: consume-to-next-request 1 cycle; imem_ready-to-instr_valid 1 cycle.
- halt never aborts REQ/DRAIN; it is sampled only on consume in HOLD, and blocks the IDLE->REQ transition.
- Reset mid-transaction: all state cleared immediately; a late imem_ready is ignored in IDLE.

Optional Feature:
IFU_STALL_CNT_EN
- Defined: adds output stall_cnt (32) counting cycles with state in {REQ, DRAIN}, plus output squash_cnt (32) counting discarded fetches (redirect in REQ/DRAIN/HOLD). Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: ifu_state_t enum (IDLE, REQ, DRAIN, HOLD), WORD_W=32, PC_INC default, PC alignment mask constant.
- Sub-module ifu_pc_reg: PC register with redirect load, increment and alignment. Natural split; FSM stays in top.

Test Plan:
- Reset then en=1, memory ready 2 cycles after req, instr_ready=1 -> imem_addr 0,4,8; instr=rdata; pc_out=0/4/8, npc_out=4/8/12.
- HOLD with instr_ready=0 for 5 cycles -> instr_valid, instr and pc_out held constant; no imem_req issued.
- REQ at pc=8, redirect_pc=32'h100 while not ready; imem_ready 3 cycles later -> DRAIN, old word discarded, instr_valid never set, next imem_addr=32'h100.
- HOLD with redirect_valid=1 and instr_ready=1 same cycle, redirect_pc=32'h203 -> redirect wins, next imem_addr=32'h200, no PC increment.
- pc=32'hFFFF_FFFC consumed -> next imem_addr=0; halt=1 on consume -> IDLE, imem_req=0 until en with halt=0.
- rst_n asserted mid-REQ -> imem_req=0 and instr_valid=0 immediately; pc=RESET_PC; IFU_STALL_CNT_EN build: counters 0.
